i2s_frame_scheduler: RTL and testbench

- Sequences the per-channel sample FIFOs of the multi-channel I2S receiver array into one AXI4-Stream master.
- Collects one sample per enabled channel, in ascending index order, to form a frame. Asserts tlast on the frame's last sample.
- A stalled channel is replaced by a zero sample after a timeout. The event is flagged as a sticky underrun.
- Sits between the receiver FIFOs and the DMA-facing m00_axis port.

---
 rtl/i2s_frame_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_i2s_frame_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_frame_scheduler.sv
// Gathers one sample per enabled I2S receiver channel, in ascending index order, into
// AXI4-Stream frames; a channel that stays empty too long is replaced by a zero sample.
module i2s_frame_scheduler #(
    parameter int unsigned I2S_RECEIVER_NUM       = 16,
    parameter int unsigned I2S_DATA_BIT_WIDTH     = 24,
    parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES         = 1024
) (
    input  logic                                         m00_axis_aclk,
    input  logic                                         m00_axis_aresetn,
    input  logic                                         enable,
    input  logic [I2S_RECEIVER_NUM-1:0]                  ch_mask,
    input  logic [I2S_RECEIVER_NUM-1:0]                  ch_valid,
    input  logic [I2S_RECEIVER_NUM*I2S_DATA_BIT_WIDTH-1:0] ch_data,
    output logic [I2S_RECEIVER_NUM-1:0]                  ch_rd,
    output logic                                         m00_axis_tvalid,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]            m00_axis_tdata,
    output logic [3:0]                                   m00_axis_tstrb,
    output logic                                         m00_axis_tlast,
    input  logic                                         m00_axis_tready,
    input  logic                                         clear_underrun,
    output logic [I2S_RECEIVER_NUM-1:0]                  underrun,
    output logic [31:0]                                  frame_count,
    output logic                                         busy
);

    localparam int unsigned N    = I2S_RECEIVER_NUM;
    localparam int unsigned W    = I2S_DATA_BIT_WIDTH;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StSend} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [N-1:0]      mask_q, mask_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       tdata_q, tdata_d;
    logic              tlast_q, tlast_d;
    logic [N-1:0]      underrun_q, underrun_d;
    logic [31:0]       frame_count_q, frame_count_d;

    logic [IdxW:0]     first_sel, next_sel;
    logic [IdxW-1:0]   first_idx, next_idx;
    logic              is_last, start_ok, head_valid, timed_out;
    logic [23:0]       sample24;
    logic [7:0]        chan8;

    // Returns {found, index} of the lowest set bit of mask at or above start.
    function automatic logic [IdxW:0] find_from(input logic [N-1:0] mask, input int start);
        logic [IdxW:0] r;
        r = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (mask[i] && (i >= start)) begin
                r = {1'b1, IdxW'(i)};
            end
        end
        return r;
    endfunction

    always_comb begin
        first_sel  = find_from(ch_mask, 0);
        next_sel   = find_from(mask_q, int'(idx_q) + 1);
        first_idx  = first_sel[IdxW-1:0];
        next_idx   = next_sel[IdxW-1:0];
        is_last    = ~next_sel[IdxW];
        start_ok   = enable && (|ch_mask);
        head_valid = ch_valid[idx_q];
        timed_out  = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
        sample24   = '0;
        sample24[W-1:0] = ch_data[int'(idx_q) * int'(W) +: W];
        chan8      = '0;
        chan8[IdxW-1:0] = idx_q;
    end

    // State register
    always_ff @(posedge m00_axis_aclk) begin
        if (!m00_axis_aresetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok) state_d = StWait;
            end
            StWait: begin
                if (head_valid || timed_out) state_d = StSend;
            end
            StSend: begin
                if (m00_axis_tready) begin
                    if (!tlast_q || start_ok) state_d = StWait;
                    else                      state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        idx_d         = idx_q;
        mask_d        = mask_q;
        cnt_d         = cnt_q;
        tdata_d       = tdata_q;
        tlast_d       = tlast_q;
        frame_count_d = frame_count_q;
        underrun_d    = clear_underrun ? '0 : underrun_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    mask_d = ch_mask;
                    idx_d  = first_idx;
                    cnt_d  = '0;
                end
            end
            StWait: begin
                if (head_valid) begin
                    tdata_d = {chan8, sample24};
                    tlast_d = is_last;
                end else if (timed_out) begin
                    tdata_d = {chan8, 24'h0};
                    tlast_d = is_last;
                    // Applied after the clear so a same-cycle timeout keeps its flag.
                    underrun_d[idx_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StSend: begin
                if (m00_axis_tready) begin
                    if (!tlast_q) begin
                        idx_d = next_idx;
                        cnt_d = '0;
                    end else begin
                        frame_count_d = frame_count_q + 32'd1;
                        if (start_ok) begin
                            mask_d = ch_mask;
                            idx_d  = first_idx;
                            cnt_d  = '0;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge m00_axis_aclk) begin
        if (!m00_axis_aresetn) begin
            idx_q         <= '0;
            mask_q        <= '0;
            cnt_q         <= '0;
            tdata_q       <= '0;
            tlast_q       <= 1'b0;
            underrun_q    <= '0;
            frame_count_q <= '0;
        end else begin
            idx_q         <= idx_d;
            mask_q        <= mask_d;
            cnt_q         <= cnt_d;
            tdata_q       <= tdata_d;
            tlast_q       <= tlast_d;
            underrun_q    <= underrun_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Outputs
    always_comb begin
        ch_rd = '0;
        if ((state_q == StWait) && head_valid && m00_axis_aresetn) begin
            ch_rd[idx_q] = 1'b1;
        end
        m00_axis_tvalid = (state_q == StSend);
        m00_axis_tdata  = tdata_q;
        m00_axis_tstrb  = 4'hF;
        m00_axis_tlast  = tlast_q;
        underrun        = underrun_q;
        frame_count     = frame_count_q;
        busy            = (state_q != StIdle);
    end

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// Directed bench for i2s_frame_scheduler with 4 channels and an 8-cycle timeout.
module tb_i2s_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [3:0]  ch_mask;
    logic [3:0]  ch_valid;
    logic [95:0] ch_data;
    logic [3:0]  ch_rd;
    logic        tvalid;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tlast;
    logic        tready;
    logic        clear_underrun;
    logic [3:0]  underrun;
    logic [31:0] frame_count;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int pops[4] = '{0, 0, 0, 0};
    int snap[4];

    i2s_frame_scheduler #(
        .I2S_RECEIVER_NUM      (4),
        .I2S_DATA_BIT_WIDTH    (24),
        .C_M00_AXIS_TDATA_WIDTH(32),
        .TIMEOUT_CYCLES        (8)
    ) dut (
        .m00_axis_aclk   (clk),
        .m00_axis_aresetn(rst_n),
        .enable          (enable),
        .ch_mask         (ch_mask),
        .ch_valid        (ch_valid),
        .ch_data         (ch_data),
        .ch_rd           (ch_rd),
        .m00_axis_tvalid (tvalid),
        .m00_axis_tdata  (tdata),
        .m00_axis_tstrb  (tstrb),
        .m00_axis_tlast  (tlast),
        .m00_axis_tready (tready),
        .clear_underrun  (clear_underrun),
        .underrun        (underrun),
        .frame_count     (frame_count),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ch_rd[i]) pops[i] <= pops[i] + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic take_snap();
        for (int i = 0; i < 4; i++) snap[i] = pops[i];
    endtask

    // Pops since the last snapshot, one byte per channel (channel 0 in the low byte).
    function automatic logic [31:0] pop_delta();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'(pops[i] - snap[i]);
        return r;
    endfunction

    task automatic wait_valid(output int waited);
        waited = 0;
        while (tvalid !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        if (tvalid !== 1'b1) check("tvalid_timeout", 64'(tvalid), 64'd1);
    endtask

    // Waits for a beat, checks {tdata,tlast}, lets it handshake (tready must be 1),
    // and checks the wait length when exp_wait >= 0.
    task automatic expect_beat(input string tag, input logic [31:0] exp_d, input logic exp_l,
                               input int exp_wait);
        int waited;
        wait_valid(waited);
        check(tag, {31'd0, tdata, tlast}, {31'd0, exp_d, exp_l});
        if (exp_wait >= 0) check({tag, "_wait"}, 64'(waited), 64'(exp_wait));
        tick();
    endtask

    initial begin
        int w;
        rst_n          = 1'b0;
        enable         = 1'b0;
        ch_mask        = 4'hF;
        ch_valid       = 4'hF;
        ch_data        = {24'h100003, 24'h100002, 24'h100001, 24'h100000};
        tready         = 1'b1;
        clear_underrun = 1'b0;
        tick();
        tick();
        check("reset_outs", {ch_rd, tvalid, tlast, busy, underrun, tdata},
              {4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0});
        check("reset_fc", 64'(frame_count), 64'd0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", 64'(busy), 64'd0);

        // Full frame, all channels
        take_snap();
        enable = 1'b1;
        expect_beat("t1_b0", 32'h00100000, 1'b0, 2);
        enable = 1'b0;
        check("t1_busy_strb", {busy, tstrb}, {1'b1, 4'hF});
        expect_beat("t1_b1", 32'h01100001, 1'b0, 1);
        expect_beat("t1_b2", 32'h02100002, 1'b0, 1);
        expect_beat("t1_b3", 32'h03100003, 1'b1, 1);
        check("t1_pops", pop_delta(), 32'h01010101);
        check("t1_fc_busy", {frame_count, busy}, {32'd1, 1'b0});

        // Sparse mask
        take_snap();
        ch_mask = 4'b1010;
        enable  = 1'b1;
        expect_beat("t2_b0", 32'h01100001, 1'b0, 2);
        enable = 1'b0;
        expect_beat("t2_b1", 32'h03100003, 1'b1, 1);
        check("t2_pops", pop_delta(), 32'h01000100);
        check("t2_fc", 64'(frame_count), 64'd2);

        // Back-pressure
        ch_mask = 4'hF;
        tready  = 1'b0;
        enable  = 1'b1;
        wait_valid(w);
        take_snap();
        for (int i = 0; i < 10; i++) begin
            check("t3_hold", {tvalid, tlast, tdata}, {1'b1, 1'b0, 32'h00100000});
            tick();
        end
        check("t3_no_pop", pop_delta(), 32'h0);
        tready = 1'b1;
        expect_beat("t3_b0", 32'h00100000, 1'b0, 0);
        enable = 1'b0;
        expect_beat("t3_b1", 32'h01100001, 1'b0, 1);
        expect_beat("t3_b2", 32'h02100002, 1'b0, 1);
        expect_beat("t3_b3", 32'h03100003, 1'b1, 1);
        check("t3_fc", 64'(frame_count), 64'd3);

        // Timeout on channel 2
        take_snap();
        ch_valid = 4'b1011;
        enable   = 1'b1;
        expect_beat("t4_b0", 32'h00100000, 1'b0, 2);
        enable = 1'b0;
        expect_beat("t4_b1", 32'h01100001, 1'b0, 1);
        expect_beat("t4_b2", 32'h02000000, 1'b0, 8);
        check("t4_underrun", 64'(underrun), 64'h4);
        expect_beat("t4_b3", 32'h03100003, 1'b1, 1);
        check("t4_pops", pop_delta(), 32'h01000101);
        clear_underrun = 1'b1;
        tick();
        clear_underrun = 1'b0;
        check("t4_cleared", {underrun, frame_count}, {4'h0, 32'd4});
        ch_valid = 4'hF;

        // Mask change mid-frame takes effect on the next frame
        enable = 1'b1;
        expect_beat("t5_b0", 32'h00100000, 1'b0, 2);
        ch_mask = 4'b0001;
        expect_beat("t5_b1", 32'h01100001, 1'b0, 1);
        expect_beat("t5_b2", 32'h02100002, 1'b0, 1);
        expect_beat("t5_b3", 32'h03100003, 1'b1, 1);
        enable = 1'b0;
        expect_beat("t5_single", 32'h00100000, 1'b1, 1);
        check("t5_idle", {frame_count, busy}, {32'd6, 1'b0});

        // Reset while in SEND
        ch_mask = 4'hF;
        tready  = 1'b0;
        enable  = 1'b1;
        wait_valid(w);
        take_snap();
        rst_n = 1'b0;
        tick();
        check("t6_reset", {tvalid, busy, ch_rd, frame_count}, {1'b0, 1'b0, 4'h0, 32'd0});
        check("t6_no_pop", pop_delta(), 32'h0);
        ch_mask = 4'b0110;
        tready  = 1'b1;
        rst_n   = 1'b1;
        expect_beat("t6_b0", 32'h01100001, 1'b0, 2);
        enable = 1'b0;
        expect_beat("t6_b1", 32'h02100002, 1'b1, 1);
        check("t6_fc", {frame_count, busy}, {32'd1, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
